video_stream_timing_gen: RTL

Drives the multi-pixel video stream consumed by `video_stream_to_window` and downstream filters from an untimed pixel source such as a frame-buffer reader. It pulls words through a valid/ready handshake during active video. It inserts horizontal and vertical blanking from run-time resolution and total sizes, and generates `line_start`/`line_end`/`frame_start`/`frame_end` markers and per-pixel valid masks. Configuration is latched once per frame, so it can change between frames without tearing.

---
 rtl/video_stream_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_stream_timing_gen.sv
// video_stream_timing_gen
//
// Turns an untimed multi-pixel source (e.g. a frame-buffer reader) into a timed video stream.
// Words are pulled through a valid/ready handshake during active video; horizontal and
// vertical blanking are inserted from run-time resolution/total sizes. The configuration is
// latched once per frame (when starting from idle and on the last cycle of every frame), so
// it may change between frames without tearing.
//
// Optional feature: define VIDEO_TIMING_GEN_UNDERFLOW_CNT_EN to add underflow_cnt_o, a
// 16-bit saturating count of underflow cycles.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-low reset
//   en_i             run request, sampled in idle and on the last cycle of each frame
//   res_x_i          active pixels per line
//   total_x_i        pixels per line including blanking (multiple of PX_PER_CLK)
//   res_y_i          active lines
//   total_y_i        lines per frame including blanking
//   src_data_i       source word, pixel 0 in the LSBs
//   src_valid_i      source word available
//   src_ready_o      word requested this cycle (decoded from state)
//   px_data_o        stream data (registered)
//   px_data_val_o    per-pixel valid (registered)
//   line_start_o / line_end_o / frame_start_o / frame_end_o   stream markers (registered)
//   busy_o           not idle
//   cfg_err_o        last latched configuration was rejected
//   underflow_o      sticky source-underflow flag
//   underflow_cnt_o  saturating underflow counter (optional)
//   underflow_clr_i  clears underflow flag and counter

module video_stream_timing_gen #(
    parameter int unsigned PX_WIDTH    = 12,
    parameter int unsigned PX_PER_CLK  = 4,
    parameter int unsigned MAX_TOTAL_X = 4096,
    parameter int unsigned MAX_TOTAL_Y = 4096,
    parameter int unsigned X_W         = $clog2(MAX_TOTAL_X + 1),
    parameter int unsigned Y_W         = $clog2(MAX_TOTAL_Y + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [X_W-1:0]                 res_x_i,
    input  logic [X_W-1:0]                 total_x_i,
    input  logic [Y_W-1:0]                 res_y_i,
    input  logic [Y_W-1:0]                 total_y_i,
    input  logic [PX_PER_CLK*PX_WIDTH-1:0] src_data_i,
    input  logic                           src_valid_i,
    output logic                           src_ready_o,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o,
    output logic                           busy_o,
    output logic                           cfg_err_o,
    output logic                           underflow_o,
`ifdef VIDEO_TIMING_GEN_UNDERFLOW_CNT_EN
    output logic [15:0]                    underflow_cnt_o,
`endif
    input  logic                           underflow_clr_i
);

    localparam int unsigned DW = PX_PER_CLK * PX_WIDTH;

    typedef enum logic [1:0] {StIdle, StActive, StHblank, StVblank} state_e;

    state_e          state_q, state_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;

    // Latched per-frame configuration
    logic [X_W-1:0]        wpl_q, twl_q;
    logic [PX_PER_CLK-1:0] mask_q;
    logic [Y_W-1:0]        res_y_q, total_y_q;

    logic cfg_err_q, cfg_err_d;
    logic latch;

    // Configuration decode straight from the inputs; only used at latch points
    logic [X_W:0]          rx_round;
    logic [X_W-1:0]        wpl_in, twl_in, rem_in, tx_rem;
    logic [PX_PER_CLK-1:0] mask_in;
    logic                  cfg_bad;

    always_comb begin
        rx_round = {1'b0, res_x_i} + (X_W+1)'(PX_PER_CLK - 1);
        wpl_in   = X_W'(rx_round / (X_W+1)'(PX_PER_CLK));
        twl_in   = total_x_i / X_W'(PX_PER_CLK);
        rem_in   = res_x_i % X_W'(PX_PER_CLK);
        tx_rem   = total_x_i % X_W'(PX_PER_CLK);
        for (int i = 0; i < int'(PX_PER_CLK); i++) begin
            mask_in[i] = (rem_in == '0) || (rem_in > X_W'(i));
        end
        cfg_bad = (res_x_i == '0) || (res_y_i == '0) || (tx_rem != '0) ||
                  (twl_in < wpl_in) || (total_y_i < res_y_i);
    end

    // Frame position decode against the latched configuration
    logic last_word, last_blank, last_act_line, last_line, has_hblank, has_vblank;

    always_comb begin
        last_word     = (x_q == wpl_q - X_W'(1));
        last_blank    = (x_q == twl_q - X_W'(1));
        last_act_line = (y_q == res_y_q - Y_W'(1));
        last_line     = (y_q == total_y_q - Y_W'(1));
        has_hblank    = (twl_q > wpl_q);
        has_vblank    = (total_y_q > res_y_q);
    end

    // Next-state logic
    logic start, frame_done;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cfg_err_d  = cfg_err_q;
        latch      = 1'b0;
        start      = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                x_d   = '0;
                y_d   = '0;
                start = en_i;
            end
            StActive: begin
                if (last_word) begin
                    if (has_hblank) begin
                        state_d = StHblank;
                        x_d     = x_q + X_W'(1);
                    end else begin
                        x_d = '0;
                        if (!last_act_line) begin
                            y_d = y_q + Y_W'(1);
                        end else if (has_vblank) begin
                            state_d = StVblank;
                            y_d     = y_q + Y_W'(1);
                        end else begin
                            frame_done = 1'b1;
                        end
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            StHblank: begin
                if (last_blank) begin
                    x_d = '0;
                    if (!last_act_line) begin
                        state_d = StActive;
                        y_d     = y_q + Y_W'(1);
                    end else if (has_vblank) begin
                        state_d = StVblank;
                        y_d     = y_q + Y_W'(1);
                    end else begin
                        frame_done = 1'b1;
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            StVblank: begin
                if (last_blank) begin
                    x_d = '0;
                    if (last_line) begin
                        frame_done = 1'b1;
                    end else begin
                        y_d = y_q + Y_W'(1);
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Last cycle of a frame: restart immediately (no gap) or fall back to idle
        if (frame_done) begin
            state_d = StIdle;
            x_d     = '0;
            y_d     = '0;
            start   = en_i;
        end

        if (start) begin
            x_d = '0;
            y_d = '0;
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
                state_d   = StIdle;
            end else begin
                cfg_err_d = 1'b0;
                latch     = 1'b1;
                state_d   = StActive;
            end
        end
    end

    // Output next-state logic
    logic [DW-1:0]         px_data_d;
    logic [PX_PER_CLK-1:0] px_val_d;
    logic                  ls_d, le_d, fs_d, fe_d;
    logic                  uf_event;
    logic                  underflow_d;

    always_comb begin
        px_data_d = '0;
        px_val_d  = '0;
        ls_d      = 1'b0;
        le_d      = 1'b0;
        fs_d      = 1'b0;
        fe_d      = 1'b0;
        if (state_q == StActive) begin
            ls_d = (x_q == '0);
            le_d = last_word;
            fs_d = (x_q == '0) && (y_q == '0);
            fe_d = last_word && last_act_line;
            if (src_valid_i) begin
                px_data_d = src_data_i;
                px_val_d  = last_word ? mask_q : '1;
            end
        end
        uf_event = (state_q == StActive) && !src_valid_i;
        // Clear wins over a coincident underflow
        underflow_d = underflow_clr_i ? 1'b0 : (underflow_o | uf_event);
    end

    assign src_ready_o = (state_q == StActive);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            wpl_q         <= '0;
            twl_q         <= '0;
            mask_q        <= '0;
            res_y_q       <= '0;
            total_y_q     <= '0;
            cfg_err_q     <= 1'b0;
            px_data_o     <= '0;
            px_data_val_o <= '0;
            line_start_o  <= 1'b0;
            line_end_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            busy_o        <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cfg_err_q     <= cfg_err_d;
            if (latch) begin
                wpl_q     <= wpl_in;
                twl_q     <= twl_in;
                mask_q    <= mask_in;
                res_y_q   <= res_y_i;
                total_y_q <= total_y_i;
            end
            px_data_o     <= px_data_d;
            px_data_val_o <= px_val_d;
            line_start_o  <= ls_d;
            line_end_o    <= le_d;
            frame_start_o <= fs_d;
            frame_end_o   <= fe_d;
            busy_o        <= (state_d != StIdle);
            underflow_o   <= underflow_d;
        end
    end

    assign cfg_err_o = cfg_err_q;

`ifdef VIDEO_TIMING_GEN_UNDERFLOW_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i || underflow_clr_i) begin
            underflow_cnt_o <= '0;
        end else if (uf_event && (underflow_cnt_o != 16'hFFFF)) begin
            underflow_cnt_o <= underflow_cnt_o + 16'd1;
        end
    end
`endif

endmodule
